// File: rtl/comp_fiber_out_pkg.sv
// Shared constants, link state encoding and PRBS polynomial for the comparator fiber link.
// The receive-side checker imports this package too, so both ends use the same taps.
package comp_fiber_out_pkg;

  localparam logic [7:0]  K_SYNC    = 8'hBC;
  localparam logic [7:0]  K_LTNCY   = 8'hFC;
  localparam logic [15:0] IDLE_WORD = 16'hBCBC;

  localparam int PRBS_W    = 48;
  localparam int PRBS_TAP0 = 47;
  localparam int PRBS_TAP1 = 46;
  localparam int PRBS_TAP2 = 20;
  localparam int PRBS_TAP3 = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } link_state_e;

  function automatic logic [PRBS_W-1:0] prbs48_next(input logic [PRBS_W-1:0] cur);
    return {cur[PRBS_W-2:0], cur[PRBS_TAP0] ^ cur[PRBS_TAP1] ^ cur[PRBS_TAP2] ^ cur[PRBS_TAP3]};
  endfunction

endpackage

// File: rtl/prbs48_gen.sv
// 48-bit PRBS generator with seed reload; load and advance together yield the word after the seed.
module prbs48_gen
  import comp_fiber_out_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = 48'hFFFFFF000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [PRBS_W-1:0] value
);

  logic [PRBS_W-1:0] base;

  assign base = load ? SEED : value;

  // NOTE: sequential state is always written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load || advance) begin
      value <= advance ? prbs48_next(base) : base;
    end
  end

endmodule

// File: rtl/comp_fiber_out.sv
// Transmit framer for the comparator fiber link: 4-word frames (sync/latency K word + 48-bit
// payload) on the GTX TX port, with IDLE -> TRAIN -> RUN link bring-up.
module comp_fiber_out
  import comp_fiber_out_pkg::*;
#(
  parameter logic [47:0] START_PATTERN = 48'hFFFFFF000000,
  parameter int          TRAIN_FRAMES  = 64,
  parameter bit          SIM_SPEEDUP   = 1'b0
) (
  input  logic        CMP_TX_CLK160,
  input  logic        RST_N,
  input  logic        TX_READY,
  input  logic        PRBS_MODE,
  input  logic        PRBS_RESTART,
  input  logic [47:0] TX_DATA_IN,
  input  logic        LTNCY_REQ,
  input  logic        ERR_INJ,
  output logic [15:0] TXDATA,
  output logic [1:0]  TXCHARISK,
  output logic        DATA_STRB,
  output logic        LTNCY_SENT,
  output logic        LTNCY_MERGED,
  output logic        LINK_RUN,
  output logic [15:0] FRAME_CNT
);

  localparam logic [7:0] TRAIN_LAST = SIM_SPEEDUP ? 8'd3 : 8'(TRAIN_FRAMES - 1);

  link_state_e state_q, state_d;
  logic [1:0]  phase_q;
  logic [7:0]  seq_q;
  logic [7:0]  train_cnt_q;
  logic [47:0] payload_q, payload_d;
  logic        ltncy_pend_q, err_pend_q, restart_pend_q;
  logic [15:0] word_d;
  logic [1:0]  isk_d;

  logic        framing, drop, frame_start;
  logic        ltncy_fire, err_fire, restart_fire;
  logic        prbs_load, prbs_advance;
  logic [47:0] prbs_value, prbs_eff;

  assign framing      = (state_q != IDLE) && TX_READY;
  assign drop         = (state_q != IDLE) && !TX_READY;
  assign frame_start  = (state_q == RUN) && TX_READY && (phase_q == 2'd0);
  // A request arriving on the frame-start edge itself is served by that frame.
  assign ltncy_fire   = frame_start && (ltncy_pend_q || LTNCY_REQ);
  assign err_fire     = frame_start && (err_pend_q || ERR_INJ);
  assign restart_fire = frame_start && restart_pend_q;
  assign prbs_eff     = restart_pend_q ? START_PATTERN : prbs_value;

  assign prbs_load    = restart_fire || drop || (state_q == TRAIN && state_d == RUN);
  assign prbs_advance = frame_start && PRBS_MODE;

  prbs48_gen #(
    .SEED (START_PATTERN)
  ) u_prbs (
    .clk     (CMP_TX_CLK160),
    .rst_n   (RST_N),
    .load    (prbs_load),
    .advance (prbs_advance),
    .value   (prbs_value)
  );

  // State register.
  always_ff @(posedge CMP_TX_CLK160 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; losing TX_READY aborts immediately, even mid-frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (TX_READY) state_d = TRAIN;
      TRAIN: begin
        if (!TX_READY) begin
          state_d = IDLE;
        end else if (phase_q == 2'd3 && train_cnt_q == TRAIN_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     if (!TX_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the word for the current phase, registered at this edge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    word_d = IDLE_WORD;
    isk_d  = 2'b11;
    if (framing) begin
      isk_d = 2'b00;
      case (phase_q)
        2'd0: begin
          word_d = {seq_q, ltncy_fire ? K_LTNCY : K_SYNC};
          isk_d  = 2'b01;
        end
        2'd1:    word_d = payload_q[15:0];
        2'd2:    word_d = payload_q[31:16];
        default: word_d = payload_q[47:32];
      endcase
    end
  end

  // Training frames carry a zero payload; error injection touches only the sent copy.
  always_comb begin
    payload_d = '0;
    if (frame_start) begin
      payload_d    = PRBS_MODE ? prbs_eff : TX_DATA_IN;
      payload_d[0] = payload_d[0] ^ err_fire;
    end
  end

  // NOTE: the payload holding register is reset too; it is ordinary state, not a memory array.
  always_ff @(posedge CMP_TX_CLK160 or negedge RST_N) begin
    if (!RST_N) begin
      phase_q        <= 2'd0;
      seq_q          <= 8'd0;
      train_cnt_q    <= 8'd0;
      payload_q      <= '0;
      ltncy_pend_q   <= 1'b0;
      err_pend_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      TXDATA         <= IDLE_WORD;
      TXCHARISK      <= 2'b11;
      DATA_STRB      <= 1'b0;
      LTNCY_SENT     <= 1'b0;
      LTNCY_MERGED   <= 1'b0;
      LINK_RUN       <= 1'b0;
      FRAME_CNT      <= 16'd0;
    end else begin
      phase_q <= framing ? phase_q + 2'd1 : 2'd0;

      if (drop) begin
        seq_q <= 8'd0;
      end else if (framing && phase_q == 2'd0) begin
        seq_q <= seq_q + 8'd1;
      end

      if (state_d != TRAIN) begin
        train_cnt_q <= 8'd0;
      end else if (phase_q == 2'd3) begin
        train_cnt_q <= train_cnt_q + 8'd1;
      end

      if (framing && phase_q == 2'd0) begin
        payload_q <= payload_d;
      end

      // Pending requests survive link drops and are consumed by the next RUN frame.
      ltncy_pend_q   <= ltncy_fire   ? 1'b0 : (ltncy_pend_q | LTNCY_REQ);
      err_pend_q     <= err_fire     ? 1'b0 : (err_pend_q | ERR_INJ);
      restart_pend_q <= restart_fire ? 1'b0 : (restart_pend_q | PRBS_RESTART);

      TXDATA       <= word_d;
      TXCHARISK    <= isk_d;
      DATA_STRB    <= frame_start;
      LTNCY_SENT   <= ltncy_fire;
      LTNCY_MERGED <= LTNCY_REQ && ltncy_pend_q;
      LINK_RUN     <= (state_d == RUN);

      if (frame_start && FRAME_CNT != 16'hFFFF) begin
        FRAME_CNT <= FRAME_CNT + 16'd1;
      end
    end
  end

endmodule
